// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target front-end that turns bus transactions into register
// write strobes and pointer-addressed reads, with START/STOP decode and address masking.
`default_nettype none

module i2c_target_regfile #(
  parameter int NUM_REGS    = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] own_addr_i,
  input  logic [6:0] addr_mask_i,
  input  logic       auto_inc_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] rd_addr_o,
  input  logic [7:0] rd_data_i,
  output logic       start_o,
  output logic       stop_o,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  localparam logic [8:0] REG_LIMIT = 9'(NUM_REGS);
  localparam logic [7:0] LAST_REG  = 8'(NUM_REGS - 1);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q;
  logic scl_s, sda_s;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic       rw;
  logic [7:0] ptr;
  logic [7:0] byte_in;
  logic       addr_match;
  logic       byte_ok;
  logic       ptr_ok;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign sda_rise  = sda_s & ~sda_q;
  assign sda_fall  = ~sda_s & sda_q;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  assign byte_in    = {shreg[6:0], sda_s};
  assign addr_match = (((byte_in[7:1] ^ own_addr_i) & ~addr_mask_i) == 7'd0);
  assign byte_ok    = ({1'b0, byte_in} < REG_LIMIT);
  assign ptr_ok     = ({1'b0, ptr} < REG_LIMIT);
  assign rd_addr_o  = ptr;

  function automatic logic [7:0] inc_ptr(input logic [7:0] p);
    return (p == LAST_REG) ? 8'd0 : p + 8'd1;
  endfunction

  // ACK states use cnt as a phase flag: first scl_fall drives, second releases.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      shreg     <= 8'd0;
      rw        <= 1'b0;
      ptr       <= 8'd0;
      sda_oe_o  <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= 8'd0;
      wr_data_o <= 8'd0;
      start_o   <= 1'b0;
      stop_o    <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      start_o <= 1'b0;
      stop_o  <= 1'b0;
      if (start_det) begin
        state    <= S_ADDR;
        cnt      <= 4'd0;
        sda_oe_o <= 1'b0;
        start_o  <= 1'b1;
        busy_o   <= 1'b1;
      end else if (stop_det) begin
        state    <= S_IDLE;
        cnt      <= 4'd0;
        sda_oe_o <= 1'b0;
        stop_o   <= 1'b1;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sda_oe_o <= 1'b0;
          end
          S_ADDR: begin
            if (scl_rise) begin
              shreg <= byte_in;
              if (cnt == 4'd7) begin
                cnt   <= 4'd0;
                rw    <= sda_s;
                state <= addr_match ? S_ADDR_ACK : S_IGNORE;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_oe_o <= 1'b1;
                cnt      <= 4'd1;
              end else begin
                cnt <= 4'd0;
                if (rw) begin
                  // Read data MSB goes out on the same edge that ends the ACK.
                  shreg    <= {rd_data_i[6:0], 1'b0};
                  sda_oe_o <= ~rd_data_i[7];
                  state    <= S_RDATA;
                end else begin
                  sda_oe_o <= 1'b0;
                  state    <= S_REG;
                end
              end
            end
          end
          S_REG: begin
            if (scl_rise) begin
              shreg <= byte_in;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                if (byte_ok) begin
                  ptr   <= byte_in;
                  state <= S_REG_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_REG_ACK: begin
            if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_oe_o <= 1'b1;
                cnt      <= 4'd1;
              end else begin
                sda_oe_o <= 1'b0;
                cnt      <= 4'd0;
                state    <= S_WDATA;
              end
            end
          end
          S_WDATA: begin
            if (scl_rise) begin
              shreg <= byte_in;
              if (cnt == 4'd7) begin
                cnt <= 4'd0;
                if (ptr_ok) begin
                  wr_en_o   <= 1'b1;
                  wr_addr_o <= ptr;
                  wr_data_o <= byte_in;
                  state     <= S_WDATA_ACK;
                end else begin
                  state <= S_IGNORE;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          S_WDATA_ACK: begin
            if (scl_fall) begin
              if (cnt == 4'd0) begin
                sda_oe_o <= 1'b1;
                cnt      <= 4'd1;
              end else begin
                sda_oe_o <= 1'b0;
                cnt      <= 4'd0;
                if (auto_inc_i) ptr <= inc_ptr(ptr);
                state <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt != 4'd0) begin
              if (cnt == 4'd8) begin
                sda_oe_o <= 1'b0;
                cnt      <= 4'd0;
                state    <= S_RDATA_ACK;
              end else begin
                sda_oe_o <= ~shreg[7];
                shreg    <= {shreg[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                cnt <= 4'd1;
                if (auto_inc_i) ptr <= inc_ptr(ptr);
              end else begin
                state <= S_IGNORE;
              end
            end else if (scl_fall && cnt == 4'd1) begin
              cnt      <= 4'd0;
              shreg    <= {rd_data_i[6:0], 1'b0};
              sda_oe_o <= ~rd_data_i[7];
              state    <= S_RDATA;
            end
          end
          S_IGNORE: begin
            sda_oe_o <= 1'b0;
          end
          default: begin
            state    <= S_IDLE;
            sda_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C controller, 16-entry register model,
// table-driven write transactions plus hand-written read/mask/range/reset sequences.
`default_nettype none

module tb_i2c_target_regfile;

  localparam int HALF = 20;
  localparam int QTR  = 10;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [6:0] own_addr, addr_mask;
  logic       auto_inc;
  logic       scl, sda_m;
  logic       sda_oe, wr_en, start_p, stop_p, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       sda_line;

  logic [7:0] regs [16];
  bit         loaded = 1'b0;
  int         n_start = 0, n_stop = 0, n_oe = 0;
  logic [15:0] wq[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;
  assign rd_data  = regs[rd_addr[3:0]];

  i2c_target_regfile #(.NUM_REGS(16), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .own_addr_i(own_addr), .addr_mask_i(addr_mask),
    .auto_inc_i(auto_inc), .scl_i(scl), .sda_i(sda_line), .sda_oe_o(sda_oe),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .start_o(start_p), .stop_o(stop_p), .busy_o(busy)
  );

  // Register model and event monitors, sampled on the inactive edge.
  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'hA0 + 8'(i);
      loaded <= 1'b1;
    end else if (wr_en) begin
      regs[wr_addr[3:0]] <= wr_data;
      wq.push_back({wr_addr, wr_data});
    end
    if (start_p) n_start <= n_start + 1;
    if (stop_p)  n_stop  <= n_stop + 1;
    if (sda_oe)  n_oe    <= n_oe + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wbit(input logic b);
    sda_m = b; wclk(QTR); scl = 1'b1; wclk(HALF); scl = 1'b0; wclk(QTR);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wclk(QTR); scl = 1'b1; wclk(QTR); b = sda_line;
    wclk(QTR); scl = 1'b0; wclk(QTR);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(nack);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl = 1'b1; wclk(HALF); sda_m = 1'b0; wclk(HALF); scl = 1'b0; wclk(QTR);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wclk(QTR); scl = 1'b1; wclk(HALF); sda_m = 1'b0; wclk(HALF);
    scl = 1'b0; wclk(QTR);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(QTR); scl = 1'b1; wclk(HALF); sda_m = 1'b1; wclk(HALF);
  endtask

  typedef struct {
    logic       ai;
    logic [7:0] ptr, d0, d1;
    logic [7:0] a0e, d0e, a1e, d1e;
    logic [7:0] ptr_end;
  } wvec_t;

  wvec_t vecs[3];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] acks;
    logic [7:0] b0, b1;
    int w0, s0, p0, o0;
    bit seen;

    vecs[0] = '{1'b1, 8'h06, 8'h11, 8'h22, 8'h06, 8'h11, 8'h07, 8'h22, 8'h08};
    vecs[1] = '{1'b0, 8'h03, 8'hAA, 8'hBB, 8'h03, 8'hAA, 8'h03, 8'hBB, 8'h03};
    vecs[2] = '{1'b1, 8'h0E, 8'h33, 8'h44, 8'h0E, 8'h33, 8'h0F, 8'h44, 8'h00};

    rst_ni = 1'b0; own_addr = 7'h40; addr_mask = 7'h00; auto_inc = 1'b1;
    scl = 1'b1; sda_m = 1'b1;
    wclk(5);
    check("reset_outputs", {sda_oe, wr_en, start_p, stop_p, busy}, 0);
    check("reset_regs_out", {wr_addr, wr_data, rd_addr}, 0);
    rst_ni = 1'b1;
    wclk(10);

    // Table-driven write transactions.
    for (int i = 0; i < 3; i++) begin
      auto_inc = vecs[i].ai;
      w0 = wq.size(); s0 = n_start; p0 = n_stop;
      i2c_start();
      check("busy_after_start", busy, 1);
      send_byte(8'h80, acks[3]);
      send_byte(vecs[i].ptr, acks[2]);
      send_byte(vecs[i].d0, acks[1]);
      send_byte(vecs[i].d1, acks[0]);
      i2c_stop();
      wclk(4);
      check($sformatf("v%0d_acks", i), acks, 4'hF);
      check($sformatf("v%0d_wr_count", i), wq.size() - w0, 2);
      if (wq.size() - w0 == 2) begin
        check($sformatf("v%0d_wr0", i), wq[w0], {vecs[i].a0e, vecs[i].d0e});
        check($sformatf("v%0d_wr1", i), wq[w0+1], {vecs[i].a1e, vecs[i].d1e});
      end
      check($sformatf("v%0d_held", i), {wr_addr, wr_data}, {vecs[i].a1e, vecs[i].d1e});
      check($sformatf("v%0d_ptr_end", i), rd_addr, vecs[i].ptr_end);
      check($sformatf("v%0d_start_cnt", i), n_start - s0, 1);
      check($sformatf("v%0d_stop_cnt", i), n_stop - p0, 1);
      check($sformatf("v%0d_busy_end", i), busy, 0);
    end

    // Pointer write, repeated START, read two bytes with wrap 0x0F -> 0x00.
    auto_inc = 1'b1;
    w0 = wq.size();
    i2c_start();
    send_byte(8'h80, acks[2]);
    send_byte(8'h0F, acks[1]);
    i2c_rstart();
    send_byte(8'h81, acks[0]);
    recv_byte(1'b0, b0);
    recv_byte(1'b1, b1);
    check("rd_acks", acks[2:0], 3'b111);
    check("rd_byte0", b0, 8'h44);
    check("rd_byte1_wrap", b1, 8'hA0);
    check("rd_release_after_nack", sda_oe, 0);
    i2c_stop();
    wclk(4);
    check("rd_no_write", wq.size() - w0, 0);
    check("rd_ptr_end", rd_addr, 8'h00);

    // Address masking: 0x43 matches 0x40 with mask 0x03, 0x44 does not.
    addr_mask = 7'h03;
    i2c_start();
    send_byte({7'h43, 1'b0}, acks[0]);
    i2c_stop();
    check("mask_hit_ack", acks[0], 1);
    w0 = wq.size(); o0 = n_oe;
    i2c_start();
    send_byte({7'h44, 1'b0}, acks[1]);
    send_byte(8'h01, acks[0]);
    i2c_stop();
    wclk(4);
    check("mask_miss_acks", acks[1:0], 2'b00);
    check("mask_miss_oe_cycles", n_oe - o0, 0);
    check("mask_miss_no_write", wq.size() - w0, 0);
    addr_mask = 7'h00;

    // Out-of-range pointer is NACKed and later data is ignored.
    w0 = wq.size();
    i2c_start();
    send_byte(8'h80, acks[2]);
    send_byte(8'h20, acks[1]);
    send_byte(8'h55, acks[0]);
    i2c_stop();
    wclk(4);
    check("oor_acks", acks[2:0], 3'b100);
    check("oor_no_write", wq.size() - w0, 0);
    check("oor_ptr_kept", rd_addr, 8'h00);

    // Reset while the address ACK is being driven.
    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(8'h80 >> i);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      if (sda_oe) seen = 1'b1; else wclk(1);
    end
    check("rst_ack_seen", seen, 1);
    rst_ni = 1'b0;
    wclk(1);
    check("rst_mid_oe_busy", {sda_oe, busy}, 2'b00);
    check("rst_mid_ptr", rd_addr, 8'h00);
    rst_ni = 1'b1;
    wclk(4);
    i2c_stop();
    w0 = wq.size();
    i2c_start();
    send_byte(8'h80, acks[2]);
    send_byte(8'h05, acks[1]);
    send_byte(8'h5A, acks[0]);
    i2c_stop();
    wclk(4);
    check("post_rst_acks", acks[2:0], 3'b111);
    check("post_rst_wr_count", wq.size() - w0, 1);
    if (wq.size() - w0 == 1) check("post_rst_wr", wq[w0], 16'h055A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Parametrised I2C target front-end for the PWM controller register file. Deglitches SCL/SDA, decodes START/repeated-START/STOP, matches a programmable 7-bit address, and converts I2C transactions into single-cycle register write strobes and registered reads. Multi-byte writes and reads auto-increment the register pointer.

## Interface
- NUM_REGS, 256: number of addressable registers. Valid indices are 0..NUM_REGS-1. Range 2..256.
- SYNC_STAGES, 2: flip-flop stages on scl_i and sda_i before edge detection. Minimum 2.
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  reset, synchronous and active-low.
- own_addr_i  in  7  target address.
- addr_mask_i  in  7  bit=1 means that address bit is ignored in the match.
- auto_inc_i  in  1  1 = pointer increments after each data byte.
- scl_i  in  1  bus SCL (raw).
- sda_i  in  1  bus SDA (raw).
- sda_oe_o  out  1  1 = pull SDA low. The pad is open-drain; 0 releases SDA.
- wr_en_o  out  1  one-cycle write strobe.
- wr_addr_o  out  8  write register index.
- wr_data_o  out  8  write data.
- rd_addr_o  out  8  current read pointer, held stable.
- rd_data_i  in  8  register contents at rd_addr_o (combinational from regfile).
- start_o  out  1  one-cycle pulse on START or repeated START.
- stop_o  out  1  one-cycle pulse on STOP.
- busy_o  out  1  high from START until STOP.

## Operation
- Synchronise scl_i and sda_i through SYNC_STAGES flip-flops. Compare the last two synchronised samples to detect rising and falling edges (scl_rise, scl_fall, sda_rise, sda_fall).
- START = sda_fall while synchronised SCL is high. STOP = sda_rise while synchronised SCL is high.
- START/STOP take priority over every state, including simultaneous SCL edges:
  - START: counter cleared; state goes to ADDR.
  - STOP: counter cleared; state goes to IDLE; sda_oe_o=0.
- Bits are sampled on scl_rise. sda_oe_o changes only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7-bit address, then R/W). Match rule: ((addr ^ own_addr_i) & ~addr_mask_i)==0. Match goes to ADDR_ACK; no match goes to IGNORE.
  - ADDR_ACK: drive low for one SCL period. Then go to RDATA if R/W=1, else REG.
  - REG: shift 8 bits into the pointer. If the value is < NUM_REGS, go to REG_ACK (ACK). Otherwise NACK (release SDA) and go to IGNORE.
  - WDATA: shift 8 bits. On the 8th scl_rise, if pointer < NUM_REGS: pulse wr_en_o with {wr_addr_o=pointer, wr_data_o=byte}, then go to WDATA_ACK (ACK). Otherwise NACK and go to IGNORE.
  - WDATA_ACK: after the ACK bit, increment the pointer if auto_inc_i=1, then return to WDATA.
  - RDATA: on the first scl_fall, load a shift register from rd_data_i. Drive MSB first: 0 means oe=1, 1 means oe=0. After 8 bits go to RDATA_ACK with SDA released.
  - RDATA_ACK: sample the controller's bit. ACK(0): increment the pointer if auto_inc_i, then go to RDATA. NACK(1): go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- Pointer wrap: NUM_REGS-1 increments to 0. The pointer persists across transactions; it is reset only by rst_ni. This lets a write-pointer transaction followed by a repeated START and read work correctly.
- Read pointer (rd_addr_o) = pointer, updated no later than the scl_rise of the ACK bit.

## Timing
- Reset (rst_ni=0 at a clk_i edge) forces, on that edge:
  - state=IDLE, pointer=0, counter=0, sync flops=1;
  - sda_oe_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, rd_addr_o=0, start_o=0, stop_o=0, busy_o=0.
- This applies mid-transaction. The bus is released immediately and no partial write is issued.
- Edge-detect latency: SYNC_STAGES+1 clk_i cycles after the pin change.
- wr_en_o: high exactly one clk_i cycle, the cycle after the 8th data-bit scl_rise is detected. wr_addr_o and wr_data_o are valid the same cycle and held until the next strobe.
- ACK drive: sda_oe_o rises on the scl_fall after the 8th bit and falls on the following scl_fall.
- rd_data_i must be valid 1 cycle after rd_addr_o changes. It is sampled on the scl_fall that begins data bit 7.
- start_o and stop_o pulse the cycle the condition is detected.
- The design requires SCL period ≥ 4·(SYNC_STAGES+2) clk_i cycles.

## Test plan
- Write, AI=1: own_addr=0x40, START 0x80, ptr 0x06, data 0x11 0x22, STOP. Expect 2 wr_en_o pulses: (0x06,0x11) and (0x07,0x22). ACK on all 4 bytes; stop_o=1 once.
- Repeated-START read, NUM_REGS=16: write ptr 0x0F, Sr, 0x81, controller ACKs 1 byte then NACKs the 2nd. Expect bytes regs[0x0F] then regs[0x00] (wrap); SDA released after the NACK; no wr_en_o.
- Address mismatch and mask: own=0x40, mask=0x03. 0x43 is ACKed; 0x44 is NACKed. For 0x44, sda_oe_o stays 0 for the whole transaction.
- Out-of-range pointer, NUM_REGS=16: ptr 0x20 is NACKed and the state goes to IGNORE. Subsequent data produces no wr_en_o.
- AI=0: ptr 0x03, data 0xAA 0xBB. Expect writes (0x03,0xAA) then (0x03,0xBB).
- Reset mid-ACK: assert rst_ni=0 while sda_oe_o=1. Next clk_i: sda_oe_o=0, busy_o=0. A following transaction with ptr 0x05 and data 0x5A writes (0x05,0x5A).
